rate_counter_bank: RTL

Multi-channel programmable rate-divided counter bank, the parametrised successor to the single-channel speed-select counter of Lab 5.
- Each of `NUM_CH` channels divides `ClockIn` by a runtime-programmable divisor and steps its own counter: up or down, wrapping or one-shot.
- Sits between board switch/keys or a controller FSM and display or HEX decoders; replaces fixed four-speed selection with a register-write interface.

---
 rtl/rate_counter_bank_pkg.sv | 9 +
 rtl/rate_counter_bank_if.sv | 9 +
 rtl/rate_counter_bank_channel.sv | 60 ++++++
 rtl/rate_counter_bank.sv | 33 +++
 4 files changed

// File: rtl/rate_counter_bank_pkg.sv
// rate_pkg: shared mode-bit indices, direction encoding and a direction helper.
package rate_pkg;
  localparam int MODE_DIR = 0;
  localparam int MODE_ONESHOT = 1;
  typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_e;
  function automatic logic is_down(input logic [1:0] mode);
    return dir_e'(mode[MODE_DIR]) == DIR_DOWN;
  endfunction
endpackage

// File: rtl/rate_counter_bank_if.sv
// rate_counter_bank_if: configuration write bus into the counter bank.
interface rate_counter_bank_if #(parameter int DIV_W = 11);
  logic WrEn;
  logic [3:0] WrCh;
  logic [DIV_W-1:0] WrDiv;
  logic [1:0] WrMode;
  modport master (output WrEn, WrCh, WrDiv, WrMode);
  modport slave (input WrEn, WrCh, WrDiv, WrMode);
endinterface

// File: rtl/rate_counter_bank_channel.sv
// rate_counter_channel: one channel's prescaler, counter, mode and sticky done.
module rate_counter_channel
  import rate_pkg::*;
#(
  parameter int DIV_W = 11,
  parameter int CNT_W = 4,
  parameter int DEF_DIV = 499
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic load,
  input  logic [DIV_W-1:0] ld_div,
  input  logic [1:0] ld_mode,
  output logic [CNT_W-1:0] cnt,
  output logic tick,
  output logic tc,
  output logic done
);
  logic [DIV_W-1:0] div_q, div_d, pre_q, pre_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, nxt, term;
  logic [1:0] mode_q, mode_d;
  logic done_q, done_d, tick_q, tick_d, tc_q, tc_d, adv, step;
  always_comb begin
    adv = run && !done_q;
    step = adv && pre_q == '0;
    nxt = is_down(mode_q) ? cnt_q - 1'b1 : cnt_q + 1'b1;
    term = {CNT_W{!is_down(mode_q)}};
    div_d = load ? ld_div : div_q;
    mode_d = load ? ld_mode : mode_q;
    pre_d = load ? ld_div : step ? div_q : adv ? pre_q - 1'b1 : pre_q;
    cnt_d = load ? {CNT_W{is_down(ld_mode)}} : step ? nxt : cnt_q;
    tick_d = !load && step;
    tc_d = tick_d && nxt == term;
    done_d = load ? 1'b0 : done_q || (tc_d && mode_q[MODE_ONESHOT]);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= DIV_W'(DEF_DIV);
      pre_q <= DIV_W'(DEF_DIV);
      cnt_q <= '0;
      mode_q <= '0;
      done_q <= 1'b0;
      tick_q <= 1'b0;
      tc_q <= 1'b0;
    end else begin
      div_q <= div_d;
      pre_q <= pre_d;
      cnt_q <= cnt_d;
      mode_q <= mode_d;
      done_q <= done_d;
      tick_q <= tick_d;
      tc_q <= tc_d;
    end
  end
  assign cnt = cnt_q;
  assign tick = tick_q;
  assign tc = tc_q;
  assign done = done_q;
endmodule

// File: rtl/rate_counter_bank.sv
// rate_counter_bank: NUM_CH independent rate-divided counters with a shared write bus.
module rate_counter_bank
  import rate_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DIV_W = 11,
  parameter int CNT_W = 4,
  parameter int DEF_DIV = 499
) (
  input  logic ClockIn,
  input  logic Reset,
  input  logic [NUM_CH-1:0] Run,
  rate_counter_bank_if.slave wr,
  output logic [NUM_CH*CNT_W-1:0] CounterValue,
  output logic [NUM_CH-1:0] Tick,
  output logic [NUM_CH-1:0] Tc,
  output logic [NUM_CH-1:0] Done
);
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    rate_counter_channel #(.DIV_W(DIV_W), .CNT_W(CNT_W), .DEF_DIV(DEF_DIV)) u_ch (
      .clk(ClockIn),
      .rst_n(Reset),
      .run(Run[g]),
      .load(wr.WrEn && wr.WrCh == 4'(g)),
      .ld_div(wr.WrDiv),
      .ld_mode(wr.WrMode),
      .cnt(CounterValue[g*CNT_W +: CNT_W]),
      .tick(Tick[g]),
      .tc(Tc[g]),
      .done(Done[g])
    );
  end
endmodule
